uart_tx_arbiter: RTL

- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Arbitrates among pending requests and latches the winner's byte and parity configuration.
- Launches the frame with a one-cycle tx_data_valid pulse, then tracks tx_busy until the frame completes.
- Sits directly in front of the UART TX top: drives its Data_Valid, P_DATA, parity_enable and parity_type, and monitors its busy.

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter.
// Fixed-priority build: define UART_TX_ARB_FIXED_PRIO_EN.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_BUSY_TIMEOUT = 15;

    function automatic int unsigned wrap_inc(
        input int unsigned v,
        input int unsigned n
    );
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// First set request at or above the pointer, wrapping around.
// UART_TX_ARB_FIXED_PRIO_EN: scan always starts at index 0.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int base;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb base = 0;
`else
    always_comb base = int'(ptr);
`endif

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = base + i;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters.
// Fixed-priority build: define UART_TX_ARB_FIXED_PRIO_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_par_en,
    input  logic [NUM_REQ-1:0]       req_par_type,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     tx_busy,
    output logic                     tx_data_valid,
    output logic [WIDTH-1:0]         tx_p_data,
    output logic                     tx_parity_enable,
    output logic                     tx_parity_type,
    output logic [IW-1:0]            grant_id,
    output logic                     timeout_err
);

    arb_state_t    state, state_n;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic          pick_valid;
    logic [CW-1:0] cnt;
    logic          grab;
    logic          done;

    rr_priority_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_n       = state;
        tx_data_valid = 1'b0;
        ack           = '0;
        timeout_err   = 1'b0;
        grab          = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                // A busy UART here means a frame we did not launch.
                if (pick_valid && !tx_busy) begin
                    grab    = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_data_valid = 1'b1;
                state_n       = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    ack[grant_id] = 1'b1;
                    state_n       = WAIT_END;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout_err = 1'b1;
                    state_n     = IDLE;
                end
            end
            WAIT_END: begin
                if (!tx_busy) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= IDLE;
            cnt              <= '0;
            tx_p_data        <= '0;
            tx_parity_enable <= 1'b0;
            tx_parity_type   <= 1'b0;
            grant_id         <= '0;
        end else begin
            state <= state_n;
            if (grab) begin
                tx_p_data        <= req_data[pick*WIDTH +: WIDTH];
                tx_parity_enable <= req_par_en[pick];
                tx_parity_type   <= req_par_type[pick];
                grant_id         <= pick;
            end
            if (state == LAUNCH) begin
                cnt <= '0;
            end else if (state == WAIT_START && !tx_busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Only a completed frame moves the pointer; a timeout retries w.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (done) begin
            ptr <= IW'(wrap_inc(32'(grant_id), NUM_REQ));
        end
    end
`endif

endmodule
